// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator front end: key words, job status codes
// and the job arbiter state encoding.
package calc_pkg;

    typedef enum logic [3:0] {
        NOP      = 4'h0,
        START    = 4'h1,
        ENTER    = 4'h2,
        ARITH_OP = 4'h3,
        DONE     = 4'h4
    } oper_t;

    typedef struct packed {
        oper_t       op;
        logic [15:0] payload;
    } keyIn_t;

    typedef enum logic [2:0] {
        ST_OK         = 3'd0,
        ST_STACK_OVF  = 3'd1,
        ST_UNEXP_DONE = 3'd2,
        ST_PROTO      = 3'd3,
        ST_DATA_OVF   = 3'd4,
        ST_TIMEOUT    = 3'd5,
        ST_BAD_START  = 3'd6,
        ST_INCORRECT  = 3'd7
    } calc_status_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_FLUSH  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } arb_state_t;

    localparam keyIn_t IDLE_KEY = '{op: NOP, payload: 16'h0};

endpackage

// File: rtl/calc_rr_arbiter.sv
// Two-requester round-robin grant. The pointer names the favoured client and
// only moves when a job completes, so a grant holds for the whole job.
module calc_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       served_i,
    output logic       gnt_any_o,
    output logic       gnt_idx_o
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        rr_d = advance_i ? ~served_i : rr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign gnt_any_o = |req_i;
    assign gnt_idx_o = req_i[rr_q] ? rr_q : ~rr_q;

endmodule

// File: rtl/calc_job_arbiter.sv
// Whole-job arbiter in front of the RPN calculator: grants one client per job,
// forwards its words to `data`, and returns a one-cycle result/status response.
module calc_job_arbiter
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  keyIn_t [1:0]       req_key,
    output logic [1:0]         req_ready,
    output logic [1:0]         rsp_valid,
    output logic [15:0]        rsp_result,
    output calc_status_t       rsp_status,
    output keyIn_t             data,
    input  logic [15:0]        result,
    input  logic               finished,
    input  logic               correct,
    input  logic               stackOverflow,
    input  logic               unexpectedDone,
    input  logic               protocolError,
    input  logic               dataOverflow,
    output arb_state_t         dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t   state_q;
    logic         gnt_q;
    logic [CW-1:0] cnt_q;
    calc_status_t status_q;
    keyIn_t       data_q;
    logic [1:0]   rsp_valid_q;
    logic [15:0]  rsp_result_q;
    calc_status_t rsp_status_q;

    logic         gnt_any, gnt_idx, cur_idx;
    keyIn_t       cur_key;
    logic         acc, acc_done, err_any, cnt_hit, fin;
    calc_status_t err_st, fin_status;
    logic [15:0]  fin_result;

    calc_rr_arbiter u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_i     (req_valid),
        .advance_i (state_q == S_RESP),
        .served_i  (gnt_q),
        .gnt_any_o (gnt_any),
        .gnt_idx_o (gnt_idx)
    );

    // In IDLE the candidate comes from the arbiter; afterwards the job owner is fixed.
    always_comb begin
        cur_idx   = (state_q == S_IDLE) ? gnt_idx : gnt_q;
        cur_key   = req_key[cur_idx];
        req_ready = '0;
        case (state_q)
            S_IDLE:            req_ready[gnt_idx] = gnt_any;
            S_STREAM, S_FLUSH: req_ready[gnt_q]   = 1'b1;
            default:           ;
        endcase
        acc      = req_valid[cur_idx] & req_ready[cur_idx];
        acc_done = acc && (cur_key.op == DONE);
        err_any  = stackOverflow | dataOverflow | protocolError | unexpectedDone;
        if (stackOverflow)      err_st = ST_STACK_OVF;
        else if (dataOverflow)  err_st = ST_DATA_OVF;
        else if (protocolError) err_st = ST_PROTO;
        else                    err_st = ST_UNEXP_DONE;
        cnt_hit = (cnt_q == CW'(TIMEOUT));
    end

    // Conditions that end the job this cycle and what the response carries.
    always_comb begin
        fin        = 1'b0;
        fin_status = status_q;
        fin_result = '0;
        case (state_q)
            S_IDLE: begin
                if (acc && cur_key.op != START) begin
                    fin        = 1'b1;
                    fin_status = ST_BAD_START;
                end
            end
            S_STREAM: begin
                if (err_any && acc_done) begin
                    fin        = 1'b1;
                    fin_status = err_st;
                end
            end
            S_FLUSH: fin = acc_done;
            S_WAIT: begin
                if (err_any) begin
                    fin        = 1'b1;
                    fin_status = err_st;
                end else if (finished) begin
                    fin        = 1'b1;
                    fin_status = correct ? ST_OK : ST_INCORRECT;
                    fin_result = result;
                end else if (cnt_hit) begin
                    fin        = 1'b1;
                    fin_status = ST_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            status_q     <= ST_OK;
            data_q       <= IDLE_KEY;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            data_q      <= IDLE_KEY;
            rsp_valid_q <= '0;
            if ((state_q == S_IDLE && acc && cur_key.op == START) ||
                (state_q == S_STREAM && acc)) begin
                data_q <= cur_key;
            end
            if (fin) begin
                rsp_valid_q[cur_idx] <= 1'b1;
                rsp_status_q         <= fin_status;
                rsp_result_q         <= fin_result;
                state_q              <= S_RESP;
            end
            case (state_q)
                S_IDLE: begin
                    if (acc) begin
                        gnt_q <= cur_idx;
                        cnt_q <= '0;
                        if (!fin) state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    cnt_q <= acc ? '0 : cnt_q + CW'(1);
                    if (!fin) begin
                        if (err_any) begin
                            status_q <= err_st;
                            state_q  <= S_FLUSH;
                        end else if (acc_done) begin
                            state_q <= S_WAIT;
                        end else if (!acc && cnt_hit) begin
                            status_q <= ST_TIMEOUT;
                            state_q  <= S_FLUSH;
                        end
                    end
                end
                S_WAIT:  cnt_q   <= cnt_q + CW'(1);
                S_RESP:  state_q <= S_IDLE;
                default: ;
            endcase
        end
    end

    assign data       = data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/calc_job_arbiter.md
# calc_job_arbiter

Shares one RPN calculator between two requesting clients at whole-job granularity. Each client streams keyIn_t words (START, ENTER, ARITH_OP, DONE); the arbiter grants one client per job and forwards its words to the calculator's `data` input. It then waits for `finished` or an error flag and returns a per-client result/status response. It sits directly in front of the calculator and owns its `data` input exclusively.

## Interface
Parameters:
- TIMEOUT, 16: max consecutive cycles without progress in STREAM (no accepted word) or in WAIT (no `finished`) before abort.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [1:0]  client i has a head word.
- req_key  in  [1:0] keyIn_t  client i head word.
- req_ready  out  [1:0]  client i head word consumed this cycle.
- rsp_valid  out  [1:0]  one-cycle response pulse to client i.
- rsp_result  out  16  result for the responding client.
- rsp_status  out  calc_status_t (3)  job outcome.
- data  out  keyIn_t  word driven to calculator.
- result  in  16  calculator result.
- finished, correct, stackOverflow, unexpectedDone, protocolError, dataOverflow  in  1 each  calculator status.

## Operation
- Status codes: OK=0, STACK_OVF=1, UNEXP_DONE=2, PROTO=3, DATA_OVF=4, TIMEOUT=5, BAD_START=6, INCORRECT=7.
- Idle word IDLE_KEY = {op 4'h0, payload 16'h0}; `data` = IDLE_KEY whenever no word is forwarded.
- FSM states: IDLE, STREAM, FLUSH, WAIT, RESP.
- IDLE:
  - Round-robin pick among clients with req_valid. rr pointer at reset favours client 0; after any RESP it points to the other client.
  - Selected client g gets req_ready[g]=1.
  - If its op is START, forward it and go to STREAM. Otherwise discard it, set status BAD_START, and go to RESP.
- STREAM:
  - req_ready[g]=1 every cycle; the other client's ready=0.
  - Each accepted word is forwarded. Words are forwarded verbatim, including nested START; the calculator flags protocol errors itself.
  - Accepted DONE: go to WAIT.
- Error flag sampled in STREAM:
  - Flag priority: stackOverflow > dataOverflow > protocolError > unexpectedDone.
  - Latch the status.
  - If the word accepted in that same cycle is DONE, go to RESP. Otherwise go to FLUSH.
- FLUSH: accept and discard client g words (data=IDLE_KEY) until a DONE is accepted, then go to RESP.
- WAIT:
  - finished && correct: status OK, capture result, go to RESP.
  - finished && !correct: status INCORRECT, capture result, go to RESP.
  - Error flag: go to RESP; flags take priority over finished in the same cycle.
- Timeout:
  - Progress counter is cleared on every accepted word and on entry to WAIT.
  - Reaching TIMEOUT in STREAM or WAIT: status TIMEOUT. From STREAM go to FLUSH; from WAIT go to RESP.
  - FLUSH has no timeout.
- RESP: rsp_valid[g]=1 for exactly one cycle; update rr; go to IDLE.
- rsp_result is 0 for every status except OK and INCORRECT.

## Timing
- Reset values: data=IDLE_KEY, req_ready=0, rsp_valid=0, rsp_result=0, rsp_status=OK, state IDLE, rr→client 0, counter 0.
- req_ready is combinational from state, rr and req_valid; all other outputs are registered.
- Word accepted in cycle N appears on `data` in cycle N+1, held for exactly one cycle.
- START accepted in IDLE cycle N: STREAM from N+1.
- DONE accepted at cycle M: data=DONE at M+1, WAIT from M+1.
- finished seen at cycle K in WAIT: rsp_valid at K+1 with result sampled at K. Earliest next grant is K+2.
- BAD_START drop at cycle N: rsp_valid at N+1, and data stays IDLE_KEY throughout.
- No response backpressure; clients must accept rsp_valid pulses.
- Reset mid-job: the job is abandoned silently with no response. Outputs take reset values in the cycle after reset is sampled.

## Structure
- Shared package `calc_pkg` holds: oper_t, keyIn_t, calc_status_t, IDLE_KEY.
- Sub-module `calc_rr_arbiter` is a 2-requester round-robin grant with an `advance` input that moves the pointer to the non-granted client. The top holds the FSM, counter and response registers.

## Test plan
- Client 0 sends START, ENTER 3, ENTER 4, ARITH_OP, DONE; calculator model asserts finished+correct, result=7 → data shows each word one cycle after acceptance, rsp_valid[0], result 7, status OK.
- Both clients present START in the first cycle after reset → client 0 served first, then client 1; the next simultaneous START goes to client 0.
- Client 1 head ENTER 5 while IDLE → req_ready[1] one cycle, rsp_valid[1] next cycle, status BAD_START, data stays IDLE_KEY.
- stackOverflow pulses after the second ENTER of a 6-word job → remaining words drained with data=IDLE_KEY, status STACK_OVF on the cycle after DONE is accepted.
- DONE forwarded and finished never asserted, TIMEOUT=16 → rsp_valid 17 cycles after WAIT entry, status TIMEOUT, result 0.
- reset asserted in WAIT → no rsp_valid; all outputs at reset values the next cycle; next job goes to client 0.
